// File: rtl/song_reader_if.sv
// song_reader_if: mcu control, song ROM port and note-player handshake of the song reader
interface song_reader_if #(
  parameter int NOTE_IDX_W = 5
);
  logic                  play;
  logic                  reset_player;
  logic [1:0]            song;
  logic [NOTE_IDX_W+1:0] rom_addr;
  logic [11:0]           rom_data;
  logic                  new_note;
  logic [5:0]            note;
  logic [5:0]            duration;
  logic                  note_done;
  logic                  song_done;
  modport master (
    output play, reset_player, song, rom_data, note_done,
    input  rom_addr, new_note, note, duration, song_done
  );
  modport slave (
    input  play, reset_player, song, rom_data, note_done,
    output rom_addr, new_note, note, duration, song_done
  );
endinterface

// File: rtl/song_reader.sv
// song_reader: walks a song in a synchronous ROM note by note, handing each note to the player
module song_reader #(
  parameter int NOTE_IDX_W = 5
) (
  input logic          clk,
  input logic          reset,
  song_reader_if.slave sr
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_NOTE, END, DONE} state_t;
  localparam logic [NOTE_IDX_W-1:0] LAST_IDX = '1;
  state_t                state_q, state_d;
  logic [NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
  logic [1:0]            song_q;
  logic [5:0]            note_q, note_d;
  logic [5:0]            duration_q, duration_d;
  logic                  new_note_q, new_note_d;
  logic                  restart;
  logic                  sentinel;
  logic                  last_note;
  assign restart   = sr.reset_player || (sr.song != song_q);
  assign sentinel  = sr.rom_data[5:0] == 6'd0;
  assign last_note = note_idx_q == LAST_IDX;
  assign sr.rom_addr  = {song_q, note_idx_q};
  assign sr.new_note  = new_note_q;
  assign sr.note      = note_q;
  assign sr.duration  = duration_q;
  assign sr.song_done = state_q == END;
  // new_note is registered out of ISSUE, so the pulse lands one cycle after ISSUE
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    note_d     = note_q;
    duration_d = duration_q;
    new_note_d = 1'b0;
    if (restart) begin
      state_d    = IDLE;
      note_idx_d = '0;
      note_d     = '0;
      duration_d = '0;
    end else begin
      case (state_q)
        IDLE:      state_d = sr.play ? FETCH : IDLE;
        FETCH:     state_d = LATCH;
        LATCH: begin
          state_d    = sentinel ? END : ISSUE;
          note_d     = sentinel ? note_q : sr.rom_data[11:6];
          duration_d = sentinel ? duration_q : sr.rom_data[5:0];
        end
        ISSUE: begin
          new_note_d = 1'b1;
          state_d    = WAIT_NOTE;
        end
        WAIT_NOTE: begin
          state_d    = (sr.note_done && sr.play) ? (last_note ? END : FETCH) : WAIT_NOTE;
          note_idx_d = (sr.note_done && sr.play && !last_note) ? note_idx_q + NOTE_IDX_W'(1) : note_idx_q;
        end
        END: begin
          state_d    = DONE;
          note_idx_d = '0;
        end
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      note_idx_q <= '0;
      song_q     <= sr.song;
      note_q     <= '0;
      duration_q <= '0;
      new_note_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      song_q     <= sr.song;
      note_q     <= note_d;
      duration_q <= duration_d;
      new_note_q <= new_note_d;
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: scoreboard bench; expected notes queued as stimulus is driven, popped on new_note
module tb_song_reader;
  logic clk;
  logic reset;
  logic [11:0] rom [128];
  logic [11:0] exp_q[$];
  int done_exp;
  int done_seen;
  int n_checks;
  int n_fail;
  song_reader_if #(.NOTE_IDX_W(5)) sr();
  song_reader #(.NOTE_IDX_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .sr   (sr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) sr.rom_data <= rom[sr.rom_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sr.new_note) begin
      check("note_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("note_val", {sr.note, sr.duration}, exp_q.pop_front());
    end
    if (sr.song_done) begin
      done_seen++;
      check("done_expected", done_exp > 0, 1);
      if (done_exp > 0) done_exp--;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_done();
    sr.note_done = 1'b1;
    tick(1);
    sr.note_done = 1'b0;
  endtask
  task automatic pulse_rp();
    sr.reset_player = 1'b1;
    tick(1);
    sr.reset_player = 1'b0;
  endtask
  task automatic wait_note();
    for (int k = 0; k < 20 && !sr.new_note; k++) tick(1);
    check("note_timeout", sr.new_note, 1);
  endtask
  task automatic wait_done();
    for (int k = 0; k < 20 && !sr.song_done; k++) tick(1);
    check("done_timeout", sr.song_done, 1);
  endtask
  task automatic run_notes(input int s, input int n);
    sr.play = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rom[{s[1:0], i[4:0]}]);
      if (i > 0) pulse_done();
      wait_note();
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int seen;
    n_checks = 0;
    n_fail = 0;
    done_exp = 0;
    done_seen = 0;
    for (int i = 0; i < 128; i++) rom[i] = 12'h0;
    for (int i = 0; i < 32; i++) rom[i] = {6'(i * 5 + 3), 6'(i % 9 + 1)};
    rom[7'h20] = {6'd5, 6'd8};
    rom[7'h21] = {6'd7, 6'd3};
    rom[7'h22] = {6'd9, 6'd12};
    rom[7'h40] = {6'd11, 6'd2};
    reset = 1'b0;
    sr.play = 1'b0;
    sr.reset_player = 1'b0;
    sr.note_done = 1'b0;
    sr.song = 2'd1;
    tick(3);
    check("rst_note", sr.note, 0);
    check("rst_dur", sr.duration, 0);
    check("rst_new_note", sr.new_note, 0);
    check("rst_song_done", sr.song_done, 0);
    reset = 1'b1;
    tick(2);
    check("rst_addr", sr.rom_addr, 7'h20);
    // first note latency: play sampled at edge N, new_note after edge N+3
    exp_q.push_back(rom[7'h20]);
    sr.play = 1'b1;
    tick(3);
    check("lat_early", sr.new_note, 0);
    tick(1);
    check("latency", sr.new_note, 1);
    check("first_note", sr.note, 5);
    check("first_dur", sr.duration, 8);
    for (int i = 1; i < 3; i++) begin
      exp_q.push_back(rom[7'h20 + i]);
      pulse_done();
      wait_note();
    end
    done_exp++;
    pulse_done();
    wait_done();
    tick(10);
    check("song1_notes_left", exp_q.size(), 0);
    check("song1_done_left", done_exp, 0);
    check("song1_done_once", done_seen, 1);
    check("done_idx", sr.rom_addr, 7'h20);
    // pause in WAIT_NOTE
    exp_q.push_back(rom[7'h20]);
    pulse_rp();
    check("rp_note", sr.note, 0);
    check("rp_dur", sr.duration, 0);
    wait_note();
    sr.play = 1'b0;
    pulse_done();
    tick(4);
    check("pause_addr", sr.rom_addr, 7'h20);
    sr.play = 1'b1;
    tick(2);
    check("play_no_done_addr", sr.rom_addr, 7'h20);
    exp_q.push_back(rom[7'h21]);
    pulse_done();
    check("adv_addr", sr.rom_addr, 7'h21);
    wait_note();
    sr.play = 1'b0;
    sr.song = 2'd0;
    tick(1);
    check("chg0_addr", sr.rom_addr, 7'h00);
    // full 32-note song
    run_notes(0, 32);
    check("last_addr", sr.rom_addr, 7'h1f);
    done_exp++;
    pulse_done();
    wait_done();
    tick(1);
    check("wrap_idx", sr.rom_addr, 7'h00);
    sr.play = 1'b0;
    tick(6);
    check("full_notes_left", exp_q.size(), 0);
    check("full_done_left", done_exp, 0);
    // reset_player beats note_done on the last note
    pulse_rp();
    run_notes(0, 32);
    seen = done_seen;
    exp_q.push_back(rom[7'h00]);
    sr.reset_player = 1'b1;
    sr.note_done = 1'b1;
    tick(1);
    sr.reset_player = 1'b0;
    sr.note_done = 1'b0;
    wait_note();
    sr.play = 1'b0;
    tick(6);
    check("prio_no_done", done_seen, seen);
    check("prio_notes_left", exp_q.size(), 0);
    // reset_player and song change at note 4
    pulse_rp();
    run_notes(0, 5);
    check("idx4_addr", sr.rom_addr, 7'h04);
    sr.play = 1'b0;
    pulse_rp();
    check("rp4_addr", sr.rom_addr, 7'h00);
    check("rp4_note", sr.note, 0);
    check("rp4_dur", sr.duration, 0);
    tick(3);
    check("rp4_idle_addr", sr.rom_addr, 7'h00);
    run_notes(0, 5);
    sr.play = 1'b0;
    sr.song = 2'd2;
    tick(1);
    check("chg2_addr", sr.rom_addr, 7'h40);
    check("chg2_note", sr.note, 0);
    check("chg2_dur", sr.duration, 0);
    tick(4);
    check("chg2_idle_addr", sr.rom_addr, 7'h40);
    // asynchronous reset in ISSUE
    seen = done_seen;
    sr.play = 1'b1;
    tick(3);
    check("issue_note", sr.note, 11);
    #2 reset = 1'b0;
    #1;
    check("async_note", sr.note, 0);
    check("async_dur", sr.duration, 0);
    check("async_new_note", sr.new_note, 0);
    check("async_song_done", sr.song_done, 0);
    sr.play = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    check("post_rst_addr", sr.rom_addr, 7'h40);
    check("post_rst_no_done", done_seen, seen);
    exp_q.push_back(rom[7'h40]);
    sr.play = 1'b1;
    wait_note();
    tick(2);
    check("end_notes_left", exp_q.size(), 0);
    check("end_done_left", done_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter: NOTE_IDX_W, default 5, note-index width; 2^NOTE_IDX_W notes per song.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-004 Port: play  in  1  level from mcu; 1 = run, 0 = pause.
REQ-005 Port: reset_player  in  1  pulse from mcu; restart current song from note 0.
REQ-006 Port: song  in  2  song select from mcu.
REQ-007 Port: rom_addr  out  2+NOTE_IDX_W  {song_q, note_idx}, combinational from registers.
REQ-008 Port: rom_data  in  12  {note[11:6], duration[5:0]}; valid one cycle after rom_addr presented (synchronous ROM).
REQ-009 Port: new_note  out  1  one-cycle pulse; note/duration valid this cycle and held after.
REQ-010 Port: note  out  6  current note code.
REQ-011 Port: duration  out  6  current note duration.
REQ-012 Port: note_done  in  1  pulse from note player when current note has finished.
REQ-013 Port: song_done  out  1  one-cycle pulse to mcu at end of song.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, LATCH, ISSUE, WAIT_NOTE, END, DONE.
REQ-015 IDLE: play=1 -> FETCH next edge; else stay.
REQ-016 FETCH: rom_addr = {song_q, note_idx}; -> LATCH unconditionally.
REQ-017 LATCH: sample rom_data; duration field == 0 -> END (end-of-song sentinel); else register note/duration, -> ISSUE.
REQ-018 ISSUE: new_note=1 for exactly this cycle; -> WAIT_NOTE.
REQ-019 Latency: play sampled high in IDLE at edge N -> new_note high in the cycle following edge N+3.
REQ-020 WAIT_NOTE: note_done=1 and play=1 -> if note_idx == 2^NOTE_IDX_W-1 -> END, else note_idx+1, -> FETCH; note_done while play=0 ignored.
REQ-021 Pause: play=0 holds FSM in IDLE or WAIT_NOTE; FETCH/LATCH/ISSUE complete their sequence regardless of play.
REQ-022 END: song_done=1 for exactly this cycle; note_idx cleared to 0; -> DONE.
REQ-023 DONE: play ignored; stay until reset_player or song change.
REQ-024 song_q SHALL register song every cycle; song != song_q (song change) SHALL be treated exactly as a reset_player pulse.
REQ-025 reset_player or song change, any state -> IDLE next edge; note_idx=0; note=0; duration=0; new_note=0; song_done=0.
REQ-026 Priority: reset/song change > note_done > play; simultaneous reset_player and note_done on last note produces no song_done.
REQ-027 note_idx SHALL never wrap silently; reaching last index always passes through END.

Reset
REQ-028 reset low: state=IDLE, note_idx=0, song_q=song, note=0, duration=0, new_note=0, song_done=0, asynchronously.
REQ-029 reset low mid-song SHALL abort without song_done; after release, FSM waits for play in IDLE.

Verification
REQ-030 Reset, song=1, play=1, ROM[1][0]={5,8} -> rom_addr=7'h20, new_note pulse 4th cycle, note=5, duration=8.
REQ-031 Song of 3 notes + sentinel (duration 0), note_done after each -> 3 new_note pulses, then single song_done pulse, state DONE, play ignored.
REQ-032 play=0 in WAIT_NOTE, note_done pulsed -> no advance; play=1 then note_done -> note_idx+1, next fetch.
REQ-033 All 32 notes non-zero duration -> after note 31 note_done, song_done pulses, note_idx=0.
REQ-034 reset_player during WAIT_NOTE at note_idx=4 -> IDLE, note_idx=0, note=0; song change 0->2 behaves identically, rom_addr=7'h40.
REQ-035 reset asserted mid-ISSUE -> outputs zero immediately, no song_done.
